piso_shift_register: RTL and testbench
======================================

Name: piso_shift_register

Overview:
Parallel-in, serial-out transmitter. It is the sending end for the serial-in left_shift_register: it accepts a WIDTH-bit word through a valid/ready load handshake and drives one bit per enabled clock on SO. With MSB_FIRST=1, the receiving left shift register holds the original word after WIDTH shifts. It sits between a word source (FSM or FIFO) and a serial link or loopback.

Parameters:
WIDTH, 4, word width in bits (>=2)
MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first (matches left-shift receiver); 0 = din[0] first

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  reset, asynchronous, active-low
load_valid  input  1  source presents a word on din
load_ready  output  1  block can accept a word this cycle
din  input  WIDTH  parallel word, sampled on the accept edge
shift_en  input  1  advance serial stream this cycle; low = stall
SO  output  1  serial data out (registered)
so_valid  output  1  SO carries a valid bit
frame_start  output  1  high while SO carries bit 0 of a word
done  output  1  high while SO carries the final bit of a word

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): state=IDLE, shreg=0, cnt=0, SO=0, so_valid=0, frame_start=0, done=0. load_ready follows state, so it is 1 during reset. Deassertion takes effect at the next edge.
- Accept: a word is accepted on a rising edge where load_valid && load_ready.
- load_ready (combinational):
  - = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1 && shift_en).
  - Never depends combinationally on load_valid.
- FSM states: IDLE, SHIFT.
- IDLE:
  - SO=0, so_valid=0.
  - On accept: shreg<=din; SO<=first bit; cnt<=0; go to SHIFT.
  - Latency: first bit is visible on SO one edge after accept.
- SHIFT, shift_en=1:
  - If cnt<WIDTH-1: cnt<=cnt+1, shreg shifts toward the output end, and SO<=next bit.
  - If cnt==WIDTH-1 with an accept on the same edge: load the new word; SO<=its first bit; cnt<=0; stay in SHIFT. No idle gap (back-to-back).
  - If cnt==WIDTH-1 with no accept: go to IDLE; SO<=0; so_valid<=0.
- SHIFT, shift_en=0: hold shreg, cnt, SO and the flags. load_ready=0 unless in IDLE.
- Bit order:
  - MSB_FIRST=1 sends din[WIDTH-1] .. din[0].
  - MSB_FIRST=0 sends din[0] .. din[WIDTH-1].
- Flags:
  - so_valid=1 exactly while state==SHIFT.
  - frame_start=so_valid && cnt==0.
  - done=so_valid && cnt==WIDTH-1.
  - All three are registered or decoded from registered state; no glitch paths from inputs.
- cnt width is $clog2(WIDTH). It never exceeds WIDTH-1, so no wrap beyond a word.
- Mid-word reset: the word is discarded and outputs return to reset values immediately. There is no partial-word completion.
- load_valid while not ready: ignored. din must be held by the source; the block does not sample it.
- X on din when no accept occurs: no effect.

Decomposition:
- Shared package piso_pkg:
  - state enum {IDLE, SHIFT}.
  - Default WIDTH constant.
  - Function first_bit(word, msb_first) for reuse by the bench scoreboard.
- One natural sub-module: piso_bit_counter. It provides cnt with clear/increment/hold and a last_bit output, and is reusable by the receiver-side framing logic.

Test Plan:
- Reset and idle: hold rst_n=0 for 2 cycles, then release. Required: SO=0, so_valid=0, load_ready=1, done=0. Assert rst_n=0 asynchronously mid-cycle; outputs clear without waiting for an edge.
- Basic MSB-first word: WIDTH=4, din=4'b1011, load_valid for one cycle, shift_en=1. Required:
  - SO = 1,0,1,1 on the 4 cycles after accept.
  - frame_start on cycle 1, done on cycle 4.
  - Return to IDLE with so_valid=0.
  - Loopback into left_shift_register gives Q=4'b1011.
- LSB-first: MSB_FIRST=0, din=4'b1011. Required: SO = 1,1,0,1.
- Back-to-back: din=4'b1100 then 4'b0011, with load_valid held. Required:
  - load_ready=1 in the done cycle.
  - SO = 1,1,0,0,0,0,1,1 contiguous with so_valid continuously 1.
  - Exactly two done pulses.
- Stall: din=4'b1010, shift_en=0 for 3 cycles after bit 2. Required:
  - SO holds 0 and cnt holds 1 during the stall.
  - Stream resumes with 1,0.
  - load_ready=0 throughout the stall.
- Reset mid-word: din=4'b1111, rst_n=0 after bit 2. Required: outputs clear immediately. A new load of 4'b0001 after release transmits 0,0,0,1 cleanly.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;
  // Widest word the first_bit helper can handle.
  localparam int unsigned MAX_WIDTH     = 32;

  // Bit that leaves the transmitter first for a given word and bit order.
  function automatic logic first_bit(input logic [MAX_WIDTH-1:0] word,
                                     input int unsigned          width,
                                     input logic                 msb_first);
    logic [MAX_WIDTH-1:0] top_aligned;
    top_aligned = word >> (width - 1);
    return msb_first ? top_aligned[0] : word[0];
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one serial word: clear, increment or hold.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_inc,
  output logic [$clog2(WIDTH)-1:0] o_cnt,
  output logic                     o_last_bit
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;

  // Clear wins over increment; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt      = r_cnt;
  assign o_last_bit = (r_cnt == LAST);

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out transmitter with valid/ready load and back-to-back words.
module piso_shift_register
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             shift_en,
  output logic             SO,
  output logic             so_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             r_so;
  logic             w_so_nxt;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic [CW-1:0]    w_cnt;
  logic             w_last;
  logic             w_accept;
  logic             w_first_bit;
  logic [WIDTH-1:0] w_shifted;
  logic             w_next_bit;

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_cnt_clr),
    .i_inc      (w_cnt_inc),
    .o_cnt      (w_cnt),
    .o_last_bit (w_last)
  );

  // Ready only from registered state and shift_en, never from load_valid.
  assign load_ready = (r_state == IDLE) || ((r_state == SHIFT) && w_last && shift_en);
  assign w_accept   = load_valid && load_ready;

  // Output end is shreg[WIDTH-1] for MSB-first, shreg[0] for LSB-first.
  assign w_first_bit = first_bit(MAX_WIDTH'(din), WIDTH, MSB_FIRST);
  assign w_shifted   = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
  assign w_next_bit  = MSB_FIRST ? w_shifted[WIDTH-1] : w_shifted[0];

  // State, shift register and serial output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_so    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_so    <= w_so_nxt;
    end
  end

  // Next-state: load on accept, advance on shift_en, reload or retire on the last bit.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_so_nxt    = r_so;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_so_nxt = 1'b0;
        if (w_accept) begin
          w_shreg_nxt = din;
          w_so_nxt    = w_first_bit;
          w_cnt_clr   = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (!w_last) begin
            w_cnt_inc   = 1'b1;
            w_shreg_nxt = w_shifted;
            w_so_nxt    = w_next_bit;
          end else if (w_accept) begin
            w_shreg_nxt = din;
            w_so_nxt    = w_first_bit;
            w_cnt_clr   = 1'b1;
          end else begin
            w_so_nxt    = 1'b0;
            w_cnt_clr   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Flags decoded from registered state only.
  assign SO          = r_so;
  assign so_valid    = (r_state == SHIFT);
  assign frame_start = so_valid && (w_cnt == '0);
  assign done        = so_valid && w_last;

endmodule

// File: tb/tb_piso_shift_register.sv
// Scoreboard bench: MSB-first and LSB-first instances share stimulus.
module tb_piso_shift_register;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic       shift_en;
  logic [3:0] din;

  logic rdy_m, so_m, sov_m, fs_m, done_m;
  logic rdy_l, so_l, sov_l, fs_l, done_l;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  logic [2:0] q_m[$];
  logic [2:0] q_l[$];
  logic [3:0] q_w[$];
  logic [3:0] rx = '0;

  piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_m),
    .din(din), .shift_en(shift_en), .SO(so_m), .so_valid(sov_m),
    .frame_start(fs_m), .done(done_m)
  );

  piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_l),
    .din(din), .shift_en(shift_en), .SO(so_l), .so_valid(sov_l),
    .frame_start(fs_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {SO, frame_start, done} per bit, hand-indexed from the word.
  task automatic push(input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      q_m.push_back({w[3-i], (i == 0), (i == 3)});
      q_l.push_back({w[i],   (i == 0), (i == 3)});
    end
    q_w.push_back(w);
  endtask

  // Monitor: a bit is consumed on each edge where so_valid and shift_en are high.
  always @(negedge clk) begin
    logic [2:0] e;
    logic [3:0] w;
    if (rst_n && shift_en && sov_m) begin
      if (q_m.size() == 0) begin
        check("msb_unexpected_bit", 32'(1), 32'(0));
      end else begin
        e = q_m.pop_front();
        check("msb_bit", 32'({so_m, fs_m, done_m}), 32'(e));
      end
      rx = {rx[2:0], so_m};
      if (done_m) begin
        done_seen++;
        if (q_w.size() == 0) begin
          check("loopback_unexpected", 32'(1), 32'(0));
        end else begin
          w = q_w.pop_front();
          check("loopback_word", 32'(rx), 32'(w));
        end
      end
    end
    if (rst_n && shift_en && sov_l) begin
      if (q_l.size() == 0) begin
        check("lsb_unexpected_bit", 32'(1), 32'(0));
      end else begin
        e = q_l.pop_front();
        check("lsb_bit", 32'({so_l, fs_l, done_l}), 32'(e));
      end
    end
  end

  task automatic send(input logic [3:0] w);
    int n;
    n = 0;
    din = w;
    load_valid = 1'b1;
    @(negedge clk);
    while (!rdy_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_m) begin
      check("load_timeout", 32'(0), 32'(1));
    end else begin
      @(posedge clk);
      push(w);
    end
    #1;
    load_valid = 1'b0;
    din = 4'bxxxx;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (sov_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_so_valid", 32'(sov_m), 32'(0));
    check("idle_SO", 32'(so_m), 32'(0));
    check("idle_ready", 32'(rdy_m), 32'(1));
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    load_valid = 1'b0;
    shift_en = 1'b1;
    din = '0;

    // Reset and idle
    @(negedge clk);
    check("rst_outputs", 32'({so_m, sov_m, rdy_m, done_m, fs_m}), 32'(5'b00100));
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_outputs", 32'({so_m, sov_m, rdy_m, done_m, fs_m}), 32'(5'b00100));

    // Basic word: MSB sends 1,0,1,1; LSB sends 1,1,0,1
    @(posedge clk); #1;
    send(4'b1011);
    wait_idle();

    // Stall on bit 2 of 1010 for three edges
    @(posedge clk); #1;
    send(4'b1010);
    @(negedge clk);
    @(posedge clk); #1;
    shift_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_SO", 32'(so_m), 32'(0));
      check("stall_cnt", 32'(dut.w_cnt), 32'(1));
      check("stall_ready", 32'(rdy_m), 32'(0));
      check("stall_valid", 32'(sov_m), 32'(1));
    end
    @(posedge clk); #1;
    shift_en = 1'b1;
    wait_idle();

    // Back-to-back 1100 then 0011 with load_valid held
    d0 = done_seen;
    @(posedge clk); #1;
    din = 4'b1100;
    load_valid = 1'b1;
    @(negedge clk);
    check("b2b_ready_idle", 32'(rdy_m), 32'(1));
    @(posedge clk);
    push(4'b1100);
    #1 din = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_valid_w0", 32'(sov_m), 32'(1));
      check("b2b_ready_w0", 32'(rdy_m), 32'(i == 3));
      @(posedge clk);
      if (i == 3) begin
        if (rdy_m) push(4'b0011);
        #1 load_valid = 1'b0;
        din = 4'bxxxx;
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_valid_w1", 32'(sov_m), 32'(1));
      @(posedge clk);
    end
    @(negedge clk);
    check("b2b_idle", 32'(sov_m), 32'(0));
    check("b2b_done_pulses", 32'(done_seen - d0), 32'(2));

    // Reset mid-word, then a clean 0001
    @(posedge clk); #1;
    send(4'b1111);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({so_m, sov_m, rdy_m, done_m, fs_m}), 32'(5'b00100));
    check("midrst_lsb_valid", 32'(sov_l), 32'(0));
    q_m.delete();
    q_l.delete();
    q_w.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'b0001);
    wait_idle();

    check("q_msb_drained", 32'(q_m.size()), 32'(0));
    check("q_lsb_drained", 32'(q_l.size()), 32'(0));
    check("q_word_drained", 32'(q_w.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
